// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment controller:
// segment patterns {A,B,C,D,E,F,G} (MSB = A, active-high) and FSM states.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Load-side handshake bundle: a value source (master) offers BCD or binary
// data to the display controller (slave).
interface sevenseg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 14
) ();

  logic                    load_valid;
  logic                    load_ready;
  logic                    bin_mode;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]        bin_in;

  modport master (
    output load_valid,
    output bin_mode,
    output bcd_in,
    output bin_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  bin_mode,
    input  bcd_in,
    input  bin_in,
    output load_ready
  );

endinterface

// File: rtl/sevenseg_scan_seg_decode.sv
// Combinational BCD nibble to seven-segment pattern; non-decimal nibbles
// light nothing.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    unique case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed N-digit seven-segment controller: BCD or binary (double-dabble)
// load, display register, prescaled digit scan and registered pin outputs.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BIN_W       = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sevenseg_scan_if.slave        ld,
  input  logic                  lzs_en,
  input  logic                  blank,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned TOT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TOT_W-1:0]     work_q, work_d, work_adj;
  logic                 oacc_q, oacc_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;

  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      dec_c;
  logic [NUM_DIGITS-1:0] zsup_c;
  logic                  zrun_c;
  logic                  sup_c;

  // Load handshake FSM and double-dabble datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    oacc_d  = oacc_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;

    work_adj = work_q;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (work_adj[BIN_W + 4*d +: 4] > 4'd4)
        work_adj[BIN_W + 4*d +: 4] = work_adj[BIN_W + 4*d +: 4] + 4'd3;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ld.load_valid && ready_q) begin
          if (ld.bin_mode) begin
            work_d  = {{BCD_W{1'b0}}, ld.bin_in};
            cnt_d   = '0;
            oacc_d  = 1'b0;
            state_d = ST_CONVERT;
          end else begin
            disp_d = ld.bcd_in;
            ovf_d  = 1'b0;
          end
        end
      end
      ST_CONVERT: begin
        // Any 1 leaving the top digit means the value needs more digits.
        work_d = {work_adj[TOT_W-2:0], 1'b0};
        oacc_d = oacc_q | work_adj[TOT_W-1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1))
          state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d  = work_q[TOT_W-1 -: BCD_W];
        ovf_d   = oacc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // Prescaler and digit index.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // zsup_c[i]: digit i and every digit above it are zero.
  always_comb begin
    zrun_c = 1'b1;
    zsup_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zrun_c    = zrun_c & (disp_q[4*i +: 4] == 4'd0);
      zsup_c[i] = zrun_c;
    end
  end

  assign nibble_c = disp_q[{idx_q, 2'b00} +: 4];

  seg_decode u_dec (
    .nibble (nibble_c),
    .seg_c  (dec_c)
  );

  // Segment and enable for the same index are registered together.
  always_comb begin
    sup_c = lzs_en && !ovf_q && (idx_q != '0) && zsup_c[idx_q];
    seg_d = dec_c;
    if (sup_c) seg_d = SEG_OFF;
    if (ovf_q) seg_d = SEG_DASH;
    if (blank) seg_d = SEG_OFF;
    den_d = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      oacc_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      den_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      oacc_q  <= oacc_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
    end
  end

  assign ld.load_ready = ready_q;
  assign seg_out       = seg_q;
  assign digit_en      = den_q;
  assign overflow      = ovf_q;

endmodule
